// File: rtl/fetch_branch_sequencer.sv
// SAP-2 fetch/branch sequencer: byte-serial opcode/operand fetch, local jump resolution, exec handshake.
// Build option CARRY_BRANCH_EN: JC/JNC are resolved here instead of being handed to the control unit.
package arch_defs_pkg;
  localparam logic [7:0] OP_HLT = 8'h76;
  localparam logic [7:0] OP_JMP = 8'hC3;
  localparam logic [7:0] OP_JZ  = 8'hCA;
  localparam logic [7:0] OP_JNZ = 8'hC2;
  localparam logic [7:0] OP_JN  = 8'hFA;
  localparam logic [7:0] OP_JC  = 8'hDA;
  localparam logic [7:0] OP_JNC = 8'hD2;
endpackage

module fetch_branch_sequencer
  import arch_defs_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_data_i,
  input  logic [1:0]  operand_count_i,
  input  logic        flag_zero_i,
  input  logic        flag_negative_i,
  input  logic        flag_carry_i,
  input  logic        exec_done_i,
  output logic [15:0] pc_o,
  output logic [7:0]  opcode_o,
  output logic [7:0]  temp_1_o,
  output logic [7:0]  temp_2_o,
  output logic        exec_o,
  output logic        branch_taken_o,
  output logic        halt_o
);

  typedef enum logic [3:0] {
    F_ADDR, F_WAIT, F_LATCH, DECODE,
    O1_ADDR, O1_WAIT, O1_LATCH,
    O2_ADDR, O2_WAIT, O2_LATCH,
    EXEC, EXEC_WAIT, HALTED
  } state_t;

  state_t state, state_next;
  logic   two_ops;
  logic   is_flow;
  logic   take;

  assign mem_addr_o = pc_o;

  // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= F_ADDR;
    else       state <= state_next;
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    is_flow = 1'b0;
    take    = 1'b0;
    case (opcode_o)
      OP_JMP: begin is_flow = 1'b1; take = 1'b1;             end
      OP_JZ:  begin is_flow = 1'b1; take = flag_zero_i;      end
      OP_JNZ: begin is_flow = 1'b1; take = !flag_zero_i;     end
      OP_JN:  begin is_flow = 1'b1; take = flag_negative_i;  end
`ifdef CARRY_BRANCH_EN
      OP_JC:  begin is_flow = 1'b1; take = flag_carry_i;     end
      OP_JNC: begin is_flow = 1'b1; take = !flag_carry_i;    end
`endif
      default: ;
    endcase
  end

`ifndef CARRY_BRANCH_EN
  logic unused_carry;
  assign unused_carry = flag_carry_i;
`endif

  always_comb begin
    state_next = state;
    case (state)
      F_ADDR:    state_next = F_WAIT;
      F_WAIT:    state_next = F_LATCH;
      F_LATCH:   state_next = DECODE;
      DECODE:    state_next = (operand_count_i == 2'd0) ? EXEC : O1_ADDR;
      O1_ADDR:   state_next = O1_WAIT;
      O1_WAIT:   state_next = O1_LATCH;
      O1_LATCH:  state_next = two_ops ? O2_ADDR : EXEC;
      O2_ADDR:   state_next = O2_WAIT;
      O2_WAIT:   state_next = O2_LATCH;
      O2_LATCH:  state_next = EXEC;
      EXEC: begin
        if (is_flow)                 state_next = F_ADDR;
        else if (opcode_o == OP_HLT) state_next = HALTED;
        else if (exec_done_i)        state_next = F_ADDR;
        else                         state_next = EXEC_WAIT;
      end
      EXEC_WAIT: if (exec_done_i) state_next = F_ADDR;
      HALTED:    state_next = HALTED;
      default:   state_next = F_ADDR;
    endcase
  end

  always_comb begin
    exec_o         = 1'b0;
    branch_taken_o = 1'b0;
    halt_o         = 1'b0;
    case (state)
      EXEC: begin
        exec_o         = !is_flow && (opcode_o != OP_HLT);
        branch_taken_o = take;
      end
      HALTED:  halt_o = 1'b1;
      default: ;
    endcase
  end

  // The read strobe is registered: it is high in each WAIT cycle, so data is valid for LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_o     <= RESET_VECTOR;
      opcode_o <= 8'h00;
      temp_1_o <= 8'h00;
      temp_2_o <= 8'h00;
      two_ops  <= 1'b0;
      mem_rd_o <= 1'b0;
    end else begin
      mem_rd_o <= (state == F_ADDR) || (state == O1_ADDR) || (state == O2_ADDR);
      case (state)
        F_LATCH: begin
          opcode_o <= mem_data_i;
          pc_o     <= pc_o + 16'd1;
        end
        DECODE:  two_ops <= operand_count_i[1];
        O1_LATCH: begin
          temp_1_o <= mem_data_i;
          pc_o     <= pc_o + 16'd1;
        end
        O2_LATCH: begin
          temp_2_o <= mem_data_i;
          pc_o     <= pc_o + 16'd1;
        end
        EXEC: if (take) pc_o <= {temp_2_o, temp_1_o};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_branch_sequencer.sv
// Self-checking bench for fetch_branch_sequencer: directed scenarios plus random instruction stream
// checked against an instruction-level model (byte counts, latency, jump rules, operand retention).
module tb_fetch_branch_sequencer;
  import arch_defs_pkg::*;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDI_A = 8'h3E;
  localparam logic [7:0] OP_LDA   = 8'h3A;
`ifdef CARRY_BRANCH_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_data_i;
  logic [1:0]  operand_count_i;
  logic        flag_zero_i, flag_negative_i, flag_carry_i;
  logic        exec_done_i;
  logic [15:0] pc_o;
  logic [7:0]  opcode_o, temp_1_o, temp_2_o;
  logic        exec_o, branch_taken_o, halt_o;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mpc;
  logic [7:0]  mt1, mt2;

  fetch_branch_sequencer dut (
    .clk(clk), .reset(reset), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_data_i(mem_data_i), .operand_count_i(operand_count_i),
    .flag_zero_i(flag_zero_i), .flag_negative_i(flag_negative_i), .flag_carry_i(flag_carry_i),
    .exec_done_i(exec_done_i), .pc_o(pc_o), .opcode_o(opcode_o), .temp_1_o(temp_1_o),
    .temp_2_o(temp_2_o), .exec_o(exec_o), .branch_taken_o(branch_taken_o), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after a strobe; otherwise it drives a junk byte.
  always @(posedge clk) mem_data_i <= mem_rd_o ? mem[mem_addr_o] : 8'hEE;

  function automatic logic [1:0] op_count(input logic [7:0] op);
    case (op)
      OP_JMP, OP_JZ, OP_JNZ, OP_JN, OP_JC, OP_JNC, OP_LDA: op_count = 2'd2;
      OP_LDI_A:                                            op_count = 2'd1;
      OP_NOP, OP_HLT:                                      op_count = 2'd0;
      default:                                             op_count = op[1:0];
    endcase
  endfunction

  assign operand_count_i = op_count(opcode_o);

  function automatic bit is_flow(input logic [7:0] op);
    is_flow = (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ) || (op == OP_JN) ||
              (CARRY_EN && ((op == OP_JC) || (op == OP_JNC)));
  endfunction

  function automatic bit jump_taken(input logic [7:0] op, input bit z, input bit n, input bit c);
    jump_taken = (op == OP_JMP) || (op == OP_JZ && z) || (op == OP_JNZ && !z) || (op == OP_JN && n) ||
                 (CARRY_EN && ((op == OP_JC && c) || (op == OP_JNC && !c)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_pc", 32'(pc_o), 32'h0000_F000);
    check("rst_opcode", 32'(opcode_o), 32'h0);
    check("rst_temp_1", 32'(temp_1_o), 32'h0);
    check("rst_temp_2", 32'(temp_2_o), 32'h0);
    check("rst_mem_rd", 32'(mem_rd_o), 32'h0);
    check("rst_exec", 32'(exec_o), 32'h0);
    check("rst_branch", 32'(branch_taken_o), 32'h0);
    check("rst_halt", 32'(halt_o), 32'h0);
  endtask

  // Leaves the bench at #1 into the first F_ADDR cycle with reset released.
  task automatic do_reset();
    reset       = 1'b1;
    exec_done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    mpc   = 16'hF000;
    mt1   = 8'h00;
    mt2   = 8'h00;
  endtask

  // Places one instruction at the model PC and runs it to the next opcode fetch.
  // Called and returning at #1 into an F_ADDR cycle. fl = {C, N, Z} when flags are not random.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                           input int d, input bit rnd, input logic [2:0] fl);
    int          n, exec_idx, len, rd_seen;
    bit          flow, hlt, taken, exp_rd;
    logic [2:0]  cur;
    logic [15:0] base, a1, a2, nxt;
    n        = (op_count(op) == 2'd0) ? 0 : ((op_count(op) == 2'd1) ? 1 : 2);
    base     = mpc;
    a1       = base + 16'd1;
    a2       = base + 16'd2;
    mem[base] = op;
    if (n >= 1) mem[a1] = b1;
    if (n == 2) mem[a2] = b2;
    flow     = is_flow(op);
    hlt      = (op == OP_HLT);
    exec_idx = 4 + 3 * n;
    len      = (flow || hlt) ? exec_idx + 1 : exec_idx + d + 1;
    taken    = 1'b0;
    rd_seen  = 0;
    for (int c = 0; c < len; c++) begin
      cur = rnd ? 3'($urandom) : fl;
      {flag_carry_i, flag_negative_i, flag_zero_i} = cur;
      if (flow || hlt) exec_done_i = rnd ? 1'($urandom) : 1'b0;
      else             exec_done_i = (c == exec_idx + d);
      if (c == exec_idx) taken = flow && jump_taken(op, cur[0], cur[1], cur[2]);
      @(negedge clk);
      exp_rd = (c == 1) || (n >= 1 && c == 5) || (n == 2 && c == 8);
      check("mem_rd", 32'(mem_rd_o), 32'(exp_rd));
      if (mem_rd_o === 1'b1) begin
        check("rd_addr", 32'(mem_addr_o), 32'(base + 16'(rd_seen)));
        rd_seen++;
      end
      check("exec_o", 32'(exec_o), 32'(!flow && !hlt && c == exec_idx));
      check("branch_taken", 32'(branch_taken_o), 32'(taken && c == exec_idx));
      check("halt_early", 32'(halt_o), 32'h0);
      @(posedge clk);
      #1;
    end
    exec_done_i = 1'b0;
    if (n >= 1) mt1 = b1;
    if (n == 2) mt2 = b2;
    nxt = taken ? {mt2, mt1} : base + 16'(1 + n);
    check("pc", 32'(pc_o), 32'(nxt));
    check("addr_eq_pc", 32'(mem_addr_o), 32'(nxt));
    check("opcode", 32'(opcode_o), 32'(op));
    check("temp_1", 32'(temp_1_o), 32'(mt1));
    check("temp_2", 32'(temp_2_o), 32'(mt2));
    check("halt", 32'(halt_o), 32'(hlt));
    check("rd_idle", 32'(mem_rd_o), 32'h0);
    mpc = nxt;
  endtask

  initial begin
    reset           = 1'b1;
    exec_done_i     = 1'b0;
    flag_zero_i     = 1'b0;
    flag_negative_i = 1'b0;
    flag_carry_i    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset during O1_WAIT of a JMP at F000 aborts it.
    do_reset();
    mem[16'hF000] = OP_JMP;
    mem[16'hF001] = 8'h34;
    mem[16'hF002] = 8'h12;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("o1_wait_rd", 32'(mem_rd_o), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    mpc = 16'hF000;
    mt1 = 8'h00;
    mt2 = 8'h00;

    // JNZ not taken (Z=1).
    run_instr(OP_LDI_A, 8'h00, 8'h00, 2, 1'b0, 3'b001);
    run_instr(OP_JNZ, 8'h0A, 8'hF0, 0, 1'b0, 3'b001);
    check("jnz_nt_pc", 32'(pc_o), 32'h0000_F005);

    // JNZ taken (Z=0), then 1-byte op with done held off 5 cycles.
    do_reset();
    run_instr(OP_LDI_A, 8'h11, 8'h00, 0, 1'b0, 3'b000);
    run_instr(OP_JNZ, 8'h0A, 8'hF0, 0, 1'b0, 3'b000);
    check("jnz_t_pc", 32'(pc_o), 32'h0000_F00A);
    run_instr(OP_NOP, 8'h00, 8'h00, 5, 1'b0, 3'b000);

    // Wrap: JMP FFFF holding a NOP.
    run_instr(OP_JMP, 8'hFF, 8'hFF, 0, 1'b1, 3'b000);
    run_instr(OP_NOP, 8'h00, 8'h00, 1, 1'b1, 3'b000);
    check("wrap_pc", 32'(pc_o), 32'h0);

    // Random instruction stream.
    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 9))
        0:       op = OP_JMP;
        1:       op = OP_JZ;
        2:       op = OP_JNZ;
        3:       op = OP_JN;
        4:       op = OP_JC;
        5:       op = OP_JNC;
        6:       op = OP_NOP;
        7:       op = OP_LDI_A;
        8:       op = OP_LDA;
        default: op = 8'($urandom);
      endcase
      if (op == OP_HLT) op = OP_NOP;
      run_instr(op, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1, 3'b000);
    end

    // JMP F00C, HLT there, then stay frozen.
    run_instr(OP_JMP, 8'h0C, 8'hF0, 0, 1'b1, 3'b000);
    run_instr(OP_HLT, 8'h00, 8'h00, 0, 1'b1, 3'b000);
    check("hlt_pc", 32'(pc_o), 32'h0000_F00D);
    for (int i = 0; i < 100; i++) begin
      {flag_carry_i, flag_negative_i, flag_zero_i} = 3'($urandom);
      exec_done_i = 1'($urandom);
      @(negedge clk);
      check("halted_halt", 32'(halt_o), 32'h1);
      check("halted_rd", 32'(mem_rd_o), 32'h0);
      check("halted_pc", 32'(pc_o), 32'h0000_F00D);
      check("halted_exec", 32'(exec_o), 32'h0);
      check("halted_branch", 32'(branch_taken_o), 32'h0);
    end
    check("halted_opcode", 32'(opcode_o), 32'(OP_HLT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
